// File: rtl/mem_pkg.sv
// ----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the load/store engine that drives the data RAM:
// CPU access op encodings, engine state encoding, lane-selection constants
// and small helpers for classifying ops and checking address alignment.
// No ports; imported by mem_access_unit and byte_lane_unit.
// ----------------------------------------------------------------------------
package mem_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  // Lane geometry of a little-endian 32-bit word.
  localparam int BYTE_W = 8;
  localparam int HALF_W = 16;
  localparam logic [1:0] WORD_OFFSET_MASK = 2'b11;
  localparam logic [1:0] HALF_OFFSET_MASK = 2'b01;

  typedef enum logic [2:0] {
    OP_LW  = 3'd0,
    OP_LH  = 3'd1,
    OP_LHU = 3'd2,
    OP_LB  = 3'd3,
    OP_LBU = 3'd4,
    OP_SW  = 3'd5,
    OP_SH  = 3'd6,
    OP_SB  = 3'd7
  } mem_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } mem_state_e;

  function automatic logic is_load(input mem_op_e op);
    return (op == OP_LW) || (op == OP_LH) || (op == OP_LHU) ||
           (op == OP_LB) || (op == OP_LBU);
  endfunction

  function automatic logic is_half(input mem_op_e op);
    return (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
  endfunction

  function automatic logic is_word(input mem_op_e op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

  // Byte accesses can never be misaligned.
  function automatic logic is_misaligned(input mem_op_e op, input logic [1:0] lo);
    logic bad;
    bad = 1'b0;
    if (is_word(op)) bad = |(lo & WORD_OFFSET_MASK);
    else if (is_half(op)) bad = |(lo & HALF_OFFSET_MASK);
    return bad;
  endfunction

  // Clears the low address bits a halfword/word access is not allowed to use,
  // so a misaligned request silently becomes the aligned one below it.
  function automatic logic [ADDR_W-1:0] force_align(input mem_op_e op,
                                                     input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] r;
    r = a;
    if (is_word(op)) r[1:0] = 2'b00;
    else if (is_half(op)) r[0] = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/byte_lane_unit.sv
// ----------------------------------------------------------------------------
// byte_lane_unit
// Purely combinational lane logic shared by the load and read-modify-write
// paths. From a 32-bit RAM word it extracts the addressed byte/half and
// extends it for loads, and it merges store data into the word for stores.
// Ports:
//   op_i          access op (mem_op_e)
//   lo_i          byte offset within the word (addr[1:0])
//   word_i        RAM word being read or modified
//   store_data_i  CPU store data (low byte/half used for SB/SH)
//   load_val_o    extended load result
//   store_word_o  word to write back
// ----------------------------------------------------------------------------
module byte_lane_unit
  import mem_pkg::*;
(
  input  mem_op_e           op_i,
  input  logic [1:0]        lo_i,
  input  logic [DATA_W-1:0] word_i,
  input  logic [DATA_W-1:0] store_data_i,
  output logic [DATA_W-1:0] load_val_o,
  output logic [DATA_W-1:0] store_word_o
);

  logic [BYTE_W-1:0] selByte;
  logic [HALF_W-1:0] selHalf;

  // Lane selection, little-endian: lane 0 is the least significant byte.
  always_comb begin
    selByte = word_i[7:0];
    case (lo_i)
      2'd0: selByte = word_i[7:0];
      2'd1: selByte = word_i[15:8];
      2'd2: selByte = word_i[23:16];
      2'd3: selByte = word_i[31:24];
      default: selByte = word_i[7:0];
    endcase
    selHalf = lo_i[1] ? word_i[31:16] : word_i[15:0];
  end

  // Load extension: signed ops replicate the lane's top bit.
  always_comb begin
    load_val_o = word_i;
    case (op_i)
      OP_LB:   load_val_o = {{(DATA_W-BYTE_W){selByte[BYTE_W-1]}}, selByte};
      OP_LBU:  load_val_o = {{(DATA_W-BYTE_W){1'b0}}, selByte};
      OP_LH:   load_val_o = {{(DATA_W-HALF_W){selHalf[HALF_W-1]}}, selHalf};
      OP_LHU:  load_val_o = {{(DATA_W-HALF_W){1'b0}}, selHalf};
      default: load_val_o = word_i;
    endcase
  end

  // Store merge: only the addressed lane is replaced, the rest of the word
  // comes from the value just read so neighbouring bytes survive the write.
  always_comb begin
    store_word_o = word_i;
    case (op_i)
      OP_SW: store_word_o = store_data_i;
      OP_SH: begin
        if (lo_i[1]) store_word_o[31:16] = store_data_i[15:0];
        else         store_word_o[15:0]  = store_data_i[15:0];
      end
      OP_SB: begin
        case (lo_i)
          2'd0: store_word_o[7:0]   = store_data_i[7:0];
          2'd1: store_word_o[15:8]  = store_data_i[7:0];
          2'd2: store_word_o[23:16] = store_data_i[7:0];
          2'd3: store_word_o[31:24] = store_data_i[7:0];
          default: store_word_o = word_i;
        endcase
      end
      default: store_word_o = word_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// ----------------------------------------------------------------------------
// mem_access_unit
// Load/store engine of the multi-cycle CPU. Turns one CPU request into RAM
// word reads/writes; sub-word stores are done as read-modify-write because
// the RAM only has a whole-word write enable.
// Ports:
//   clk, rst     clock (rising edge) and synchronous active-high reset
//   req          access request, only looked at in IDLE
//   op           0=LW 1=LH 2=LHU 3=LB 4=LBU 5=SW 6=SH 7=SB
//   addr, wdata  byte address and store data
//   busy         engine not idle
//   done         one-cycle completion pulse
//   rdata        registered, extended load result
//   addr_err     misaligned request rejected (valid with done)
//   ram_we, ram_addr, ram_wdata, ram_rdata   data RAM interface
// Parameter CHECK_ALIGN: 1 rejects misaligned half/word accesses, 0 clears
// the offending low address bits instead.
// ----------------------------------------------------------------------------
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int CHECK_ALIGN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              addr_err,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam bit CheckAlign = (CHECK_ALIGN != 0);

  mem_state_e        state_q, state_d;
  mem_op_e           op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  mem_op_e           reqOp;
  logic [DATA_W-1:0] laneWord;
  logic [DATA_W-1:0] loadValue;
  logic [DATA_W-1:0] storeWord;

  assign reqOp = mem_op_e'(op);

  // Loads extract from the live RAM data so rdata is ready at the end of
  // READ; the RMW path works from the word captured during READ.
  assign laneWord = (state_q == ST_READ) ? ram_rdata : word_q;

  byte_lane_unit u_lane (
    .op_i         (op_q),
    .lo_i         (addr_q[1:0]),
    .word_i       (laneWord),
    .store_data_i (wdata_q),
    .load_val_o   (loadValue),
    .store_word_o (storeWord)
  );

  // Next-state and datapath update logic.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    word_d  = word_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          op_d    = reqOp;
          addr_d  = CheckAlign ? addr : force_align(reqOp, addr);
          wdata_d = wdata;
          err_d   = 1'b0;
          if (CheckAlign && is_misaligned(reqOp, addr[1:0])) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else if (reqOp == OP_SW) begin
            state_d = ST_WRITE;
          end else begin
            state_d = ST_READ;
          end
        end
      end
      ST_READ: begin
        word_d = ram_rdata;
        if (is_load(op_q)) begin
          rdata_d = loadValue;
          state_d = ST_DONE;
        end else begin
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_LW;
      addr_q  <= '0;
      wdata_q <= '0;
      word_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      word_q  <= word_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Reset gates the write enable combinationally so a reset landing on the
  // WRITE cycle cannot commit a half-finished read-modify-write.
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign rdata     = rdata_q;
  assign addr_err  = err_q;
  assign ram_we    = (state_q == ST_WRITE) & ~rst;
  assign ram_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign ram_wdata = (state_q == ST_WRITE) ? storeWord : '0;

endmodule

// File: tb/tb_mem_access_unit.sv
// ----------------------------------------------------------------------------
// tb_mem_access_unit
// Directed bench for mem_access_unit with a small word-addressed RAM model.
// A second instance with CHECK_ALIGN=0 reads the same RAM to cover the
// address-forcing mode.
// ----------------------------------------------------------------------------
module tb_mem_access_unit;

  logic        clk;
  logic        rst;
  logic        req;
  logic        req2;
  logic [2:0]  op;
  logic [31:0] addr;
  logic [31:0] wdata;

  logic        busy, done, addr_err, ram_we;
  logic [31:0] rdata, ram_addr, ram_wdata, ram_rdata;

  logic        busy2, done2, addr_err2, ram_we2;
  logic [31:0] rdata2, ram_addr2, ram_wdata2, ram_rdata2;

  logic [31:0] mem [0:63];

  int checkCount;
  int passCount;

  int          lat;
  int          weCount;
  logic [31:0] lastWdata;
  logic [31:0] lastWaddr;

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: combinational read, whole-word write on the rising edge.
  assign ram_rdata  = mem[ram_addr[7:2]];
  assign ram_rdata2 = mem[ram_addr2[7:2]];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr[7:2]] <= ram_wdata;
  end

  mem_access_unit #(.CHECK_ALIGN(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .op        (op),
    .addr      (addr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .rdata     (rdata),
    .addr_err  (addr_err),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  mem_access_unit #(.CHECK_ALIGN(0)) dutNoAlign (
    .clk       (clk),
    .rst       (rst),
    .req       (req2),
    .op        (op),
    .addr      (addr),
    .wdata     (wdata),
    .busy      (busy2),
    .done      (done2),
    .rdata     (rdata2),
    .addr_err  (addr_err2),
    .ram_we    (ram_we2),
    .ram_addr  (ram_addr2),
    .ram_wdata (ram_wdata2),
    .ram_rdata (ram_rdata2)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Presents one request to the aligned instance, drops req after the
  // acceptance edge, then waits (bounded) for done. Latency counts the
  // falling edges after acceptance up to and including the done cycle.
  task automatic applyStimulus(input logic [2:0] o, input logic [31:0] a,
                               input logic [31:0] d);
    @(negedge clk);
    op    = o;
    addr  = a;
    wdata = d;
    req   = 1'b1;
    weCount = 0;
    lat     = 99;
    @(posedge clk);
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      req = 1'b0;
      if (ram_we) begin
        weCount++;
        lastWdata = ram_wdata;
        lastWaddr = ram_addr;
      end
      if (done) begin
        lat = n;
        break;
      end
    end
    if (lat == 99) $display("[TB] FAIL timeout: op %0d addr 0x%08h never completed", o, a);
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    rst   = 1'b1;
    req   = 1'b0;
    req2  = 1'b0;
    op    = 3'd0;
    addr  = '0;
    wdata = '0;
    lastWdata = '0;
    lastWaddr = '0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[4]  = 32'h8899AABB;
    mem[8]  = 32'h11223344;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset busy",      {31'b0, busy},     32'h0);
    checkOutput("reset done",      {31'b0, done},     32'h0);
    checkOutput("reset addr_err",  {31'b0, addr_err}, 32'h0);
    checkOutput("reset ram_we",    {31'b0, ram_we},   32'h0);
    checkOutput("reset rdata",     rdata,             32'h0);
    checkOutput("reset ram_addr",  ram_addr,          32'h0);
    checkOutput("reset ram_wdata", ram_wdata,         32'h0);
    rst = 1'b0;

    // Loads.
    applyStimulus(3'd0, 32'h10, 32'h0);
    checkOutput("LW rdata",   rdata,   32'h8899AABB);
    checkOutput("LW latency", lat,     32'd2);
    checkOutput("LW no we",   weCount, 32'd0);
    checkOutput("LW busy",    {31'b0, busy}, 32'h1);

    applyStimulus(3'd3, 32'h13, 32'h0);
    checkOutput("LB rdata",  rdata, 32'hFFFFFF88);
    applyStimulus(3'd4, 32'h13, 32'h0);
    checkOutput("LBU rdata", rdata, 32'h00000088);
    applyStimulus(3'd1, 32'h12, 32'h0);
    checkOutput("LH rdata",  rdata, 32'hFFFF8899);
    applyStimulus(3'd2, 32'h10, 32'h0);
    checkOutput("LHU rdata", rdata, 32'h0000AABB);
    checkOutput("LHU latency", lat, 32'd2);

    // Read-modify-write stores.
    applyStimulus(3'd7, 32'h21, 32'hFFFFFFAB);
    checkOutput("SB we pulses", weCount,   32'd1);
    checkOutput("SB wdata",     lastWdata, 32'h1122AB44);
    checkOutput("SB waddr",     lastWaddr, 32'h20);
    checkOutput("SB latency",   lat,       32'd3);
    checkOutput("SB mem",       mem[8],    32'h1122AB44);

    applyStimulus(3'd6, 32'h22, 32'h0000CDEF);
    checkOutput("SH we pulses", weCount,   32'd1);
    checkOutput("SH wdata",     lastWdata, 32'hCDEFAB44);
    checkOutput("SH mem",       mem[8],    32'hCDEFAB44);

    // Full-word store.
    applyStimulus(3'd5, 32'h30, 32'hDEADBEEF);
    checkOutput("SW we pulses", weCount,   32'd1);
    checkOutput("SW waddr",     lastWaddr, 32'h30);
    checkOutput("SW latency",   lat,       32'd2);
    checkOutput("SW mem",       mem[12],   32'hDEADBEEF);
    checkOutput("rdata kept after stores", rdata, 32'h0000AABB);

    // Misaligned accesses are rejected.
    applyStimulus(3'd0, 32'h31, 32'h0);
    checkOutput("LW misaligned err",     {31'b0, addr_err}, 32'h1);
    checkOutput("LW misaligned latency", lat,     32'd1);
    checkOutput("LW misaligned no we",   weCount, 32'd0);
    checkOutput("LW misaligned rdata",   rdata,   32'h0000AABB);
    applyStimulus(3'd6, 32'h33, 32'h00001234);
    checkOutput("SH misaligned err",     {31'b0, addr_err}, 32'h1);
    checkOutput("SH misaligned latency", lat,     32'd1);
    checkOutput("SH misaligned no we",   weCount, 32'd0);
    checkOutput("SH misaligned mem",     mem[12], 32'hDEADBEEF);

    // Next good access clears the error.
    applyStimulus(3'd0, 32'h30, 32'h0);
    checkOutput("LW after err rdata", rdata, 32'hDEADBEEF);
    checkOutput("LW after err clear", {31'b0, addr_err}, 32'h0);

    // Alignment forcing on the CHECK_ALIGN=0 instance.
    @(negedge clk);
    op   = 3'd0;
    addr = 32'h31;
    req2 = 1'b1;
    lat  = 99;
    @(posedge clk);
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      req2 = 1'b0;
      if (done2) begin
        lat = n;
        break;
      end
    end
    checkOutput("noalign LW latency", lat,    32'd2);
    checkOutput("noalign LW rdata",   rdata2, 32'hDEADBEEF);
    checkOutput("noalign LW err",     {31'b0, addr_err2}, 32'h0);

    // Reset landing on the WRITE cycle of an SB.
    @(negedge clk);
    op    = 3'd7;
    addr  = 32'h11;
    wdata = 32'h00000055;
    req   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("rst in WRITE we",   {31'b0, ram_we}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rst mem unchanged", mem[4],    32'h8899AABB);
    checkOutput("rst busy",          {31'b0, busy},     32'h0);
    checkOutput("rst done",          {31'b0, done},     32'h0);
    checkOutput("rst addr_err",      {31'b0, addr_err}, 32'h0);
    checkOutput("rst rdata",         rdata,     32'h0);
    checkOutput("rst ram_addr",      ram_addr,  32'h0);
    checkOutput("rst ram_wdata",     ram_wdata, 32'h0);

    applyStimulus(3'd0, 32'h10, 32'h0);
    checkOutput("LW after rst rdata",   rdata, 32'h8899AABB);
    checkOutput("LW after rst latency", lat,   32'd2);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
